// File: rtl/rr_arbiter8_if.sv
// Handshake bundle between the round-robin arbiter and the downstream 8-way mux/consumer.
// The master side is the arbiter; the slave side supplies requests and accepts beats.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       out_ready;
  logic [2:0] select;
  logic [7:0] grant;
  logic       out_valid;

  modport master (
    input  req,
    input  out_ready,
    output select,
    output grant,
    output out_valid
  );

  modport slave (
    output req,
    output out_ready,
    input  select,
    input  grant,
    input  out_valid
  );
endinterface

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters with optional multi-beat bursts.
// All outputs are registered; select/grant stay stable until the current grant is released.
module rr_arbiter8 #(
  parameter int BurstLen = 1
) (
  input  logic          clock,
  input  logic          reset,
  rr_arbiter8_if.master bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  localparam logic [7:0] LastBeat = 8'(BurstLen - 1);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] beats_q, beats_d;
  logic [2:0] select_q, select_d;
  logic [7:0] grant_q, grant_d;
  logic       valid_q, valid_d;

  logic       hs;
  logic       cur_req;
  logic       rel;
  pick_t      pk;

  // First set bit of r scanning start, start+1, ... with modulo-8 wrap.
  function automatic pick_t pick(input logic [7:0] r, input logic [2:0] start);
    pick_t      res;
    logic [2:0] idx;
    res = '{found: 1'b0, idx: 3'd0};
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (r[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    beats_d  = beats_q;
    select_d = select_q;
    grant_d  = grant_q;
    valid_d  = valid_q;

    hs      = valid_q && bus.out_ready;
    cur_req = bus.req[select_q];
    rel     = 1'b0;
    pk      = '{found: 1'b0, idx: 3'd0};

    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          pk       = pick(bus.req, ptr_q);
          select_d = pk.idx;
          grant_d  = 8'b1 << pk.idx;
          beats_d  = 8'd0;
          valid_d  = 1'b1;
          state_d  = GRANT;
        end
      end

      GRANT: begin
        if (hs) beats_d = beats_q + 8'd1;
        // A dropped request releases even under backpressure (requester protocol error).
        rel = !cur_req || (bus.out_ready && (beats_q == LastBeat));
        if (rel) begin
          ptr_d = select_q + 3'd1;
          // Scanning from select+1 reaches the released source last, so it only
          // wins again when no other requester is asserting.
          pk = pick(bus.req, ptr_d);
          if (pk.found) begin
            select_d = pk.idx;
            grant_d  = 8'b1 << pk.idx;
            beats_d  = 8'd0;
          end else begin
            grant_d = 8'd0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 3'd0;
      beats_q  <= 8'd0;
      select_q <= 3'd0;
      grant_q  <= 8'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      beats_q  <= beats_d;
      select_q <= select_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.select    = select_q;
  assign bus.grant     = grant_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: one instance with BurstLen=1 and one with BurstLen=4.
// Stimulus queues the expected select of every valid cycle; monitors pop and compare.
module tb_rr_arbiter8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_a, reset_b;
  logic [7:0] req_a, req_b;
  logic       rdy_a, rdy_b;

  rr_arbiter8_if ia ();
  rr_arbiter8_if ib ();

  assign ia.req       = req_a;
  assign ia.out_ready = rdy_a;
  assign ib.req       = req_b;
  assign ib.out_ready = rdy_b;

  rr_arbiter8 #(.BurstLen(1)) dut_a (.clock(clock), .reset(reset_a), .bus(ia));
  rr_arbiter8 #(.BurstLen(4)) dut_b (.clock(clock), .reset(reset_b), .bus(ib));

  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_a[$];
  logic [2:0] exp_b[$];
  logic [2:0] ea, eb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Monitors: every valid cycle consumes one queued expectation.
  always @(negedge clock) begin
    if (ia.out_valid === 1'b1) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_beat actual select=%0d required no beat at %0t", ia.select, $time);
      end else begin
        ea = exp_a.pop_front();
        check("a_select", 32'(ia.select), 32'(ea));
        check("a_grant", 32'(ia.grant), 32'(8'h01 << ea));
      end
    end else begin
      check("a_idle_grant", 32'(ia.grant), 32'h0);
    end
  end

  always @(negedge clock) begin
    if (ib.out_valid === 1'b1) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_beat actual select=%0d required no beat at %0t", ib.select, $time);
      end else begin
        eb = exp_b.pop_front();
        check("b_select", 32'(ib.select), 32'(eb));
        check("b_grant", 32'(ib.grant), 32'(8'h01 << eb));
      end
    end else begin
      check("b_idle_grant", 32'(ib.grant), 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_a = 1'b1; req_a = 8'hFF; rdy_a = 1'b1;
    reset_b = 1'b1; req_b = 8'h00; rdy_b = 1'b1;

    // Reset held with all requests asserted.
    repeat (3) begin
      cyc();
      check("a_reset_valid", 32'(ia.out_valid), 32'h0);
      check("a_reset_grant", 32'(ia.grant), 32'h0);
      check("a_reset_select", 32'(ia.select), 32'h0);
    end

    // Full rotation starting at source 0 right after reset.
    for (int i = 0; i < 10; i++) exp_a.push_back(3'(i % 8));
    reset_a = 1'b0;
    repeat (10) cyc();
    req_a = 8'h00;
    cyc();
    check("a_rotation_end_valid", 32'(ia.out_valid), 32'h0);

    // Single requester: 1-cycle latency, re-granted with no gap.
    repeat (3) exp_a.push_back(3'd5);
    req_a = 8'h20;
    cyc();
    check("a_single_latency", 32'(ia.out_valid), 32'h1);
    repeat (2) cyc();
    req_a = 8'h00;
    cyc();
    check("a_single_end_valid", 32'(ia.out_valid), 32'h0);

    // Backpressure: source 2 held while out_ready is low, then source 3.
    repeat (6) exp_a.push_back(3'd2);
    exp_a.push_back(3'd3);
    req_a = 8'h0C;
    rdy_a = 1'b0;
    repeat (6) cyc();
    rdy_a = 1'b1;
    cyc();
    req_a = 8'h00;
    cyc();
    check("a_backpressure_end_valid", 32'(ia.out_valid), 32'h0);

    // Burst instance: 4 beats of 0, 4 of 7, then 0 again.
    reset_b = 1'b0;
    cyc();
    foreach (exp_b[i]) ;
    for (int i = 0; i < 10; i++) exp_b.push_back((i < 4 || i >= 8) ? 3'd0 : 3'd7);
    req_b = 8'h81;
    repeat (10) cyc();
    req_b = 8'h00;
    cyc();
    check("b_burst_end_valid", 32'(ib.out_valid), 32'h0);

    // Dropping req[0] during its second beat releases after that beat.
    for (int i = 0; i < 8; i++) exp_b.push_back((i == 4 || i == 5) ? 3'd0 : 3'd7);
    req_b = 8'h81;
    repeat (6) cyc();
    req_b = 8'h80;
    repeat (2) cyc();
    req_b = 8'h00;
    cyc();
    check("b_drop_end_valid", 32'(ib.out_valid), 32'h0);

    // Move ptr to 4 by a short grant to source 3.
    repeat (2) exp_b.push_back(3'd3);
    req_b = 8'h08;
    repeat (2) cyc();
    req_b = 8'h00;
    cyc();
    check("b_prep_end_valid", 32'(ib.out_valid), 32'h0);

    // Reset in the middle of a burst to source 3; ptr restarts at 0.
    repeat (3) exp_b.push_back(3'd3);
    req_b = 8'h08;
    repeat (3) cyc();
    reset_b = 1'b1;
    req_b   = 8'h88;
    cyc();
    check("b_midreset_valid", 32'(ib.out_valid), 32'h0);
    check("b_midreset_grant", 32'(ib.grant), 32'h0);
    check("b_midreset_select", 32'(ib.select), 32'h0);
    reset_b = 1'b0;
    exp_b.push_back(3'd3);
    cyc();
    check("b_rearb_valid", 32'(ib.out_valid), 32'h1);
    req_b = 8'h00;
    cyc();
    check("b_rearb_end_valid", 32'(ib.out_valid), 32'h0);

    cyc();
    check("a_queue_left", 32'(exp_a.size()), 32'h0);
    check("b_queue_left", 32'(exp_b.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
